// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, double-buffered display
// data committed only at frame boundaries, per-digit blanking and blinking.
module seg7_scan_driver #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   hexs,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     le,
    input  logic [DIGITS-1:0]     blink,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_start,
    output logic                  upd_pending
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);

    logic [CW-1:0]         preCnt;
    logic [IW-1:0]         digitIdx;
    logic [BLINK_LOG2-1:0] frameCnt;
    logic                  blinkPhase;
    logic                  pending;
    logic                  wrapD1;

    logic [4*DIGITS-1:0]   stageHex, dispHex;
    logic [DIGITS-1:0]     stagePt, dispPt;
    logic [DIGITS-1:0]     stageLe, dispLe;
    logic [DIGITS-1:0]     stageBlink, dispBlink;

    logic                  scanTick;
    logic                  frameEdge;
    logic [3:0]            curHex;
    logic [6:0]            curSegs;
    logic [7:0]            segNext;
    logic [DIGITS-1:0]     anNext;

    assign scanTick    = (preCnt == LAST_CNT);
    assign frameEdge   = scanTick && (digitIdx == LAST_IDX);
    assign upd_pending = pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            preCnt      <= '0;
            digitIdx    <= '0;
            frameCnt    <= '0;
            blinkPhase  <= 1'b0;
            pending     <= 1'b0;
            wrapD1      <= 1'b0;
            frame_start <= 1'b0;
            stageHex    <= '0;
            stagePt     <= '0;
            stageLe     <= '0;
            stageBlink  <= '0;
            dispHex     <= '0;
            dispPt      <= '0;
            dispLe      <= '0;
            dispBlink   <= '0;
            seg_n       <= '1;
            an_n        <= '1;
        end else begin
            preCnt <= scanTick ? '0 : preCnt + 1'b1;
            if (scanTick) begin
                digitIdx <= (digitIdx == LAST_IDX) ? '0 : digitIdx + 1'b1;
            end
            // frame_start lines up with the first registered output of digit 0
            wrapD1      <= frameEdge;
            frame_start <= wrapD1;

            if (frameEdge) begin
                frameCnt <= frameCnt + 1'b1;
                if (frameCnt == '1) begin
                    blinkPhase <= ~blinkPhase;
                end
                if (pending) begin
                    dispHex   <= stageHex;
                    dispPt    <= stagePt;
                    dispLe    <= stageLe;
                    dispBlink <= stageBlink;
                end
            end

            // A load on the boundary edge restages after the old stage is committed
            if (load) begin
                stageHex   <= hexs;
                stagePt    <= points;
                stageLe    <= le;
                stageBlink <= blink;
                pending    <= 1'b1;
            end else if (frameEdge) begin
                pending <= 1'b0;
            end

            seg_n <= segNext;
            an_n  <= anNext;
        end
    end

    always_comb begin
        curHex = dispHex[{digitIdx, 2'b00} +: 4];
        case (curHex)
            4'h0:    curSegs = 7'h3F;
            4'h1:    curSegs = 7'h06;
            4'h2:    curSegs = 7'h5B;
            4'h3:    curSegs = 7'h4F;
            4'h4:    curSegs = 7'h66;
            4'h5:    curSegs = 7'h6D;
            4'h6:    curSegs = 7'h7D;
            4'h7:    curSegs = 7'h07;
            4'h8:    curSegs = 7'h7F;
            4'h9:    curSegs = 7'h6F;
            4'hA:    curSegs = 7'h77;
            4'hB:    curSegs = 7'h7C;
            4'hC:    curSegs = 7'h39;
            4'hD:    curSegs = 7'h5E;
            4'hE:    curSegs = 7'h79;
            default: curSegs = 7'h71;
        endcase

        segNext = '1;
        anNext  = '1;
        if (dispLe[digitIdx]) begin
            anNext[digitIdx] = 1'b0;
            if (!(dispBlink[digitIdx] && blinkPhase)) begin
                segNext = ~{dispPt[digitIdx], curSegs};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based reference
// model (digit slot and frame number derived from elapsed cycles since reset).
module tb_seg7_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int BL = 1;
    localparam int FR = D * SD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   hexs = '0;
    logic [3:0]    points = '0;
    logic [3:0]    le = '0;
    logic [3:0]    blink = '0;
    logic [7:0]    seg_n;
    logic [3:0]    an_n;
    logic          frame_start;
    logic          upd_pending;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          n = 0;
    int          frames = 0;
    bit          phase = 0;
    bit          pend = 0;
    bit          wrapPrev = 0;
    logic [15:0] stHex = '0, dHex = '0;
    logic [3:0]  stPt = '0, dPt = '0, stLe = '0, dLe = '0, stBl = '0, dBl = '0;

    string letters [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_LOG2(BL)) dut (
        .clk(clk), .rst(rst), .load(load), .hexs(hexs), .points(points), .le(le),
        .blink(blink), .seg_n(seg_n), .an_n(an_n), .frame_start(frame_start),
        .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segsOf(string s);
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic tick(bit r, bit ld, logic [15:0] h, logic [3:0] p, logic [3:0] e, logic [3:0] b);
        int k;
        logic [7:0] expSeg;
        logic [3:0] expAn;
        bit expFs;
        rst = r; load = ld; hexs = h; points = p; le = e; blink = b;
        @(posedge clk);
        // outputs after this edge reflect the model state before it
        k = (n / SD) % D;
        expSeg = 8'hFF;
        expAn  = 4'hF;
        expFs  = wrapPrev;
        if (dLe[k]) begin
            expAn = ~(4'b0001 << k);
            if (!(dBl[k] && phase)) expSeg = ~{dPt[k], segsOf(letters[dHex[4*k +: 4]])};
        end
        if (r) begin
            expSeg = 8'hFF; expAn = 4'hF; expFs = 0;
            n = 0; frames = 0; phase = 0; pend = 0; wrapPrev = 0;
            stHex = '0; dHex = '0; stPt = '0; dPt = '0;
            stLe = '0; dLe = '0; stBl = '0; dBl = '0;
        end else begin
            n++;
            wrapPrev = (n % FR == 0);
            if (wrapPrev) begin
                if (pend) begin
                    dHex = stHex; dPt = stPt; dLe = stLe; dBl = stBl; pend = 0;
                end
                frames++;
                phase = ((frames / (1 << BL)) % 2) == 1;
            end
            if (ld) begin
                stHex = h; stPt = p; stLe = e; stBl = b; pend = 1;
            end
        end
        #1;
        checkVal("seg_n", 32'(seg_n), 32'(expSeg));
        checkVal("an_n", 32'(an_n), 32'(expAn));
        checkVal("frame_start", 32'(frame_start), 32'(expFs));
        checkVal("upd_pending", 32'(upd_pending), 32'(pend));
        checkVal("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
    endtask

    task automatic idle(int cnt);
        for (int i = 0; i < cnt; i++)
            tick(0, 0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic ld(logic [15:0] h, logic [3:0] p, logic [3:0] e, logic [3:0] b);
        tick(0, 1, h, p, e, b);
    endtask

    initial begin
        tick(1, 0, '0, '0, '0, '0);
        tick(1, 1, 16'hFFFF, 4'hF, 4'hF, 4'h0);
        idle(3);
        ld(16'h3210, 4'h0, 4'hF, 4'h0);
        idle(40);
        ld(16'h3210, 4'h0, 4'b1011, 4'h0);
        idle(36);
        ld(16'h1111, 4'h0, 4'hF, 4'h0);
        idle(2);
        ld(16'hFFFF, 4'h0, 4'hF, 4'h0);
        idle(40);
        ld(16'h3210, 4'h5, 4'hF, 4'b0001);
        idle(5 * FR);
        // load landing exactly on the frame boundary while pending
        ld(16'hAAAA, 4'h0, 4'hF, 4'h0);
        while ((n + 1) % FR != 0) idle(1);
        ld(16'h5555, 4'hF, 4'hF, 4'h0);
        idle(2 * FR + 4);
        // reset in the middle of digit 2
        ld(16'h7777, 4'h0, 4'hF, 4'h0);
        while (!((n / SD) % D == 2 && n % SD == 1)) idle(1);
        tick(1, 0, '0, '0, '0, '0);
        idle(20);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(299) == 0, $urandom_range(7) == 0,
                 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
